// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_pkg : shared multiplier datapath sizes and resolver FSM states  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mult_pkg;

    localparam int MULT_WIDTH = 64;
    localparam int MULT_CHUNK = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } cpa_state_e;

endpackage
`default_nettype wire

// File: rtl/cpa_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpa_chunk : combinational CHUNK-bit adder slice with carry in/out    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpa_chunk
    import mult_pkg::*;
#(
    parameter int CHUNK = MULT_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/cpa_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpa_resolver : multi-cycle carry-propagate adder resolving a 3:2     |
// | sum/carry pair CHUNK bits per cycle, LSB first.        Rev 1.0       |
// +----------------------------------------------------------------------+
module cpa_resolver
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CHUNK = MULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);

    localparam int              NCHUNK = WIDTH / CHUNK;
    localparam int              K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [K_W-1:0]  K_LAST = K_W'(NCHUNK - 1);

    cpa_state_e       state_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_vec_q;
    logic [WIDTH-1:0] result_q;
    logic [K_W-1:0]   k_q;
    logic             cin_q;
    logic             cout_q;
    logic             valid_q;

    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;

    assign w_chunk_a = sum_q[int'(k_q)*CHUNK +: CHUNK];
    assign w_chunk_b = carry_vec_q[int'(k_q)*CHUNK +: CHUNK];

    // One adder slice, time-multiplexed across all chunks of the operands.
    cpa_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (w_chunk_a),
        .b_i    (w_chunk_b),
        .cin_i  (cin_q),
        .sum_o  (w_chunk_sum),
        .cout_o (w_chunk_cout)
    );

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_cout   = cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            carry_vec_q <= '0;
            result_q    <= '0;
            k_q         <= '0;
            cin_q       <= 1'b0;
            cout_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sum_q       <= in_sum;
                        carry_vec_q <= in_carry;
                        k_q         <= '0;
                        cin_q       <= 1'b0;
                        state_q     <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    // Chunks not yet reached keep whatever they held before.
                    result_q[int'(k_q)*CHUNK +: CHUNK] <= w_chunk_sum;
                    cin_q <= w_chunk_cout;
                    if (k_q == K_LAST) begin
                        cout_q  <= w_chunk_cout;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
